// File: rtl/fos_pkg.sv
// fos_pkg: shared constants, FSM states and Booth helper for the inverse first-order section
package fos_pkg;
    localparam int DW = 32;
    localparam int CW = 11;
    localparam int MUL_CYCLES = (CW + 1) / 2;

    typedef enum logic [1:0] {IDLE, MUL, SUM, OUT} state_t;

    function automatic logic [DW-1:0] booth_pp(input logic [DW-1:0] m, input logic [2:0] d);
        return (d == 3'b001 || d == 3'b010) ? m :
               (d == 3'b011) ? m << 1 :
               (d == 3'b100) ? -(m << 1) :
               (d == 3'b101 || d == 3'b110) ? -m : '0;
    endfunction
endpackage

// File: rtl/fos_inverse_seq_if.sv
// fos_inverse_seq_if: sample-in / sample-out handshake bundle of the inverse section
interface fos_inverse_seq_if
    import fos_pkg::*;
();
    logic [DW-1:0] y_in;
    logic [CW-1:0] a1;
    logic [CW-1:0] b1;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [DW-1:0] x_out;
    logic          out_valid;
    logic          out_ready;

    modport master(output y_in, a1, b1, in_valid, flush, out_ready, input in_ready, x_out, out_valid);
    modport slave(input y_in, a1, b1, in_valid, flush, out_ready, output in_ready, x_out, out_valid);
endinterface

// File: rtl/booth_r4_serial_mult.sv
// booth_r4_serial_mult: signed DW x CW radix-4 Booth multiplier, one digit per cycle, DW-bit product
module booth_r4_serial_mult
    import fos_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [CW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] p
);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    logic [DW-1:0]    m;
    logic [CW+1:0]    q;
    logic [CW+1:0]    qs;
    logic [CNT_W-1:0] cnt;

    assign qs   = {b[CW-1], b, 1'b0};
    assign busy = cnt != '0;

    // Start consumes digit 0 immediately; remaining digits shift through m/q one per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p    <= '0;
            m    <= '0;
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            p    <= booth_pp(a, qs[2:0]);
            m    <= a << 2;
            q    <= qs >> 2;
            cnt  <= CNT_W'(MUL_CYCLES - 1);
            done <= 1'b0;
        end else if (busy) begin
            p    <= p + booth_pp(m, q[2:0]);
            m    <= m << 2;
            q    <= q >> 2;
            cnt  <= cnt - 1'b1;
            done <= cnt == CNT_W'(1);
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/fos_inverse_seq.sv
// fos_inverse_seq: recovers x[n] = y[n] - a1*y[n-1] - b1*x[n-1] (mod 2^DW); FOS_INV_PARALLEL_MUL_EN selects two multipliers
module fos_inverse_seq
    import fos_pkg::*;
(
    input logic              clk,
    input logic              reset_n,
    fos_inverse_seq_if.slave bus
);
    state_t        state, state_nx;
    logic [1:0]    ph, ph_nx;
    logic [DW-1:0] y_lat, y_prev, x_prev, x_q, x_new, p_a, p_b;
    logic [CW-1:0] a_lat, b_lat;
    logic          accept, hist_clr, start, mul_done;

    assign accept        = bus.in_valid && state == IDLE;
    assign hist_clr      = bus.flush && (state == IDLE || state == OUT);
    assign x_new         = y_lat - p_a - p_b;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == OUT;
    assign bus.x_out     = x_q;

`ifdef FOS_INV_PARALLEL_MUL_EN
    logic busy_a, busy_b, done_a, done_b;

    assign start    = state == MUL && ph == 2'd0 && !busy_a && !busy_b;
    assign mul_done = ph == 2'd1 && done_a && done_b;

    booth_r4_serial_mult u_mul_a (
        .clk, .reset_n, .start, .a(y_prev), .b(a_lat), .busy(busy_a), .done(done_a), .p(p_a)
    );
    booth_r4_serial_mult u_mul_b (
        .clk, .reset_n, .start, .a(x_prev), .b(b_lat), .busy(busy_b), .done(done_b), .p(p_b)
    );
`else
    logic          busy, done;
    logic [DW-1:0] prod;

    assign start    = state == MUL && !busy && (ph == 2'd0 || (ph == 2'd1 && done));
    assign mul_done = ph == 2'd2 && done;
    assign p_b      = prod;

    booth_r4_serial_mult u_mul (
        .clk, .reset_n, .start,
        .a(ph == 2'd0 ? y_prev : x_prev), .b(ph == 2'd0 ? a_lat : b_lat),
        .busy, .done, .p(prod)
    );

    // Hold a1*y_prev while the shared multiplier moves on to b1*x_prev
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) p_a <= '0;
        else if (ph == 2'd1 && done) p_a <= prod;
    end
`endif

    // State and multiplier phase registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ph    <= 2'd0;
        end else begin
            state <= state_nx;
            ph    <= ph_nx;
        end
    end

    // Next state: phase advances on each multiplier start, resets when the products are ready
    always_comb begin
        state_nx = state;
        ph_nx    = start ? ph + 2'd1 : ph;
        if (state == IDLE && accept) state_nx = MUL;
        if (mul_done) begin
            state_nx = SUM;
            ph_nx    = 2'd0;
        end
        if (state == SUM) state_nx = OUT;
        if (state == OUT && bus.out_ready) state_nx = IDLE;
    end

    // Sample latch, history update and output register; flush wins on the accept edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_lat  <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            y_prev <= '0;
            x_prev <= '0;
            x_q    <= '0;
        end else begin
            if (accept) begin
                y_lat <= bus.y_in;
                a_lat <= bus.a1;
                b_lat <= bus.b1;
            end
            if (hist_clr) begin
                y_prev <= '0;
                x_prev <= '0;
            end else if (state == SUM) begin
                y_prev <= y_lat;
                x_prev <= x_new;
            end
            if (state == SUM) x_q <= x_new;
        end
    end
endmodule

// File: tb/tb_fos_inverse_seq.sv
// tb_fos_inverse_seq: directed and random checks of the inverse section against a forward/inverse reference model
module tb_fos_inverse_seq;
    import fos_pkg::*;

`ifdef FOS_INV_PARALLEL_MUL_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 14;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fos_inverse_seq_if bus();
    fos_inverse_seq dut(.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int my = 0, mx = 0;
    int fy = 0, fx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dec(input logic [31:0] y, input logic [10:0] a, input logic [10:0] b, input bit fl);
        logic [31:0] x;
        if (fl) begin
            my = 0;
            mx = 0;
        end
        x = y - int'($signed(a)) * my - int'($signed(b)) * mx;
        my = y;
        mx = x;
        return x;
    endfunction

    function automatic logic [31:0] enc(input logic [31:0] x, input logic [10:0] a, input logic [10:0] b);
        logic [31:0] y;
        y = x + int'($signed(b)) * fx + int'($signed(a)) * fy;
        fx = x;
        fy = y;
        return y;
    endfunction

    task automatic issue(input logic [31:0] y, input logic [10:0] a, input logic [10:0] b, input bit fl);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready before accept", bus.in_ready, 1);
        bus.y_in = y;
        bus.a1 = a;
        bus.b1 = b;
        bus.flush = fl;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid after release", bus.out_valid, 0);
        chk("in_ready after release", bus.in_ready, 1);
    endtask

    task automatic run(input logic [31:0] y, input logic [10:0] a, input logic [10:0] b, input bit fl,
                       input logic [31:0] exp, input string tag);
        int lat;
        issue(y, a, b, fl);
        wait_out(lat);
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " x_out"}, bus.x_out, exp);
        finish_out();
    endtask

    initial begin
        logic [31:0] x, y, hold;
        logic [10:0] a, b;
        int lat;
        bus.y_in = '0;
        bus.a1 = '0;
        bus.b1 = '0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset x_out", bus.x_out, 0);
        chk("reset y_prev", dut.y_prev, 0);
        chk("reset x_prev", dut.x_prev, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after reset", bus.in_ready, 1);

        run(32'h12345678, 11'd0, 11'd0, 1'b0, dec(32'h12345678, 11'd0, 11'd0, 1'b0), "zero coef");
        chk("zero coef literal", bus.x_out, 32'h12345678);

        run(32'd5, 11'd3, 11'd2, 1'b1, 32'd5, "fwd5");
        void'(dec(32'd5, 11'd3, 11'd2, 1'b1));
        run(32'd32, 11'd3, 11'd2, 1'b0, 32'd7, "fwd32");
        void'(dec(32'd32, 11'd3, 11'd2, 1'b0));
        chk("hist y_prev", dut.y_prev, 32);
        chk("hist x_prev", dut.x_prev, 7);

        fy = 0;
        fx = 0;
        for (int i = 0; i < 1000; i++) begin
            x = (i % 50 == 0) ? 32'h7FFFFFFF : (i % 50 == 1) ? 32'h80000000 :
                (i % 50 == 2) ? 32'h80000000 : (i % 50 == 3) ? 32'h7FFFFFFF : $urandom;
            y = enc(x, 11'h400, 11'h3FF);
            void'(dec(y, 11'h400, 11'h3FF, i == 0));
            run(y, 11'h400, 11'h3FF, i == 0, x, "wrap");
        end

        for (int i = 0; i < 100; i++) begin
            y = $urandom;
            a = 11'($urandom);
            b = 11'($urandom);
            run(y, a, b, 1'b0, dec(y, a, b, 1'b0), "rand coef");
        end

        y = $urandom;
        issue(y, 11'd5, 11'h7FB, 1'b0);
        hold = dec(y, 11'd5, 11'h7FB, 1'b0);
        wait_out(lat);
        chk("bp x_out", bus.x_out, hold);
        bus.y_in = $urandom;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp hold x_out", bus.x_out, hold);
            chk("bp hold out_valid", bus.out_valid, 1);
            chk("bp hold in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        finish_out();
        y = $urandom;
        run(y, 11'd7, 11'd9, 1'b0, dec(y, 11'd7, 11'd9, 1'b0), "after bp");

        issue(32'd100, 11'd3, 11'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset out_valid", bus.out_valid, 0);
        chk("midreset x_out", bus.x_out, 0);
        chk("midreset y_prev", dut.y_prev, 0);
        chk("midreset x_prev", dut.x_prev, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        my = 0;
        mx = 0;
        run(32'd9, 11'd3, 11'd2, 1'b0, dec(32'd9, 11'd3, 11'd2, 1'b0), "post reset");
        chk("post reset literal", bus.x_out, 9);

        y = $urandom;
        run(y, 11'd3, 11'd2, 1'b0, dec(y, 11'd3, 11'd2, 1'b0), "build hist");
        void'(dec(32'd40, 11'd3, 11'd2, 1'b1));
        run(32'd40, 11'd3, 11'd2, 1'b1, 32'd40, "flush accept");
        run(32'd50, 11'd3, 11'd2, 1'b0, dec(32'd50, 11'd3, 11'd2, 1'b0), "build hist2");
        issue(32'd60, 11'd3, 11'd2, 1'b0);
        bus.flush = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.flush = 1'b0;
        wait_out(lat);
        chk("flush in MUL x_out", bus.x_out, dec(32'd60, 11'd3, 11'd2, 1'b0));
        finish_out();
        chk("flush in MUL y_prev", dut.y_prev, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
